// File: rtl/clk_div_bank_if.sv
// Divisor write port and per-channel divider outputs for clk_div_bank.
// The master side writes divisors and realigns; the slave side produces rates.
interface clk_div_bank_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 20,
    parameter int CH_W   = 3
);
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DIV_W-1:0]  wr_data;
    logic              sync;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] active;

    modport master (
        output wr_en, wr_ch, wr_data, sync,
        input  clk_out, tick, active
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, sync,
        output clk_out, tick, active
    );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-enable divider with run-time divisors.
// Define CLKDIV_CASCADE_EN to chain channel k off the tick of channel k-1.
module clk_div_bank #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 20,
    parameter int DEF_DIV = 49,
    parameter int CH_W    = 3
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_bank_if.slave bus
);
    localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] act_q;
    logic [NUM_CH-1:0] adv;

    always_comb begin
        adv = '1;
`ifdef CLKDIV_CASCADE_EN
        // Registered tick of the previous stage gates this one
        for (int k = 1; k < NUM_CH; k++) begin
            adv[k] = tick_q[k-1];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                div_q[k]  <= DEF_D;
                cnt_q[k]  <= '0;
                clk_q[k]  <= 1'b0;
                tick_q[k] <= 1'b0;
                act_q[k]  <= (DEF_D != '0);
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.wr_en && bus.wr_ch == CH_W'(k)) begin
                    div_q[k]  <= bus.wr_data;
                    act_q[k]  <= (bus.wr_data != '0);
                    cnt_q[k]  <= '0;
                    clk_q[k]  <= 1'b0;
                    tick_q[k] <= 1'b0;
                end else if (bus.sync || div_q[k] == '0) begin
                    cnt_q[k]  <= '0;
                    clk_q[k]  <= 1'b0;
                    tick_q[k] <= 1'b0;
                end else if (adv[k]) begin
                    if (cnt_q[k] == div_q[k]) begin
                        cnt_q[k]  <= '0;
                        clk_q[k]  <= ~clk_q[k];
                        tick_q[k] <= ~clk_q[k];
                    end else begin
                        cnt_q[k]  <= cnt_q[k] + DIV_W'(1);
                        tick_q[k] <= 1'b0;
                    end
                end else begin
                    tick_q[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.clk_out = clk_q;
    assign bus.tick    = tick_q;
    assign bus.active  = act_q;
endmodule
